// File: rtl/wb_stage.sv
// Write-back stage: holds the MEM bundle for one cycle, aligns load data, drives the register-file
// write port and keeps the cycle/instret performance counters.
module wb_stage #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_load,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_alu,
    input  logic [31:0]          in_br,
    input  logic [4:0]           in_rd,
    input  logic                 in_regwrite,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_load_type,
    input  logic [31:0]          in_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_wdata,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret_cnt
);

    logic                 fresh_q;
    logic [31:0]          pc_q;
    logic [31:0]          alu_q;
    logic [31:0]          br_q;
    logic [31:0]          rdata_q;
    logic [4:0]           rd_q;
    logic                 regwrite_q;
    logic [1:0]           wb_sel_q;
    logic [2:0]           load_type_q;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] instret_q;

    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        mis_cond;
    logic        we;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic [31:0] wdata_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_q     <= 1'b0;
            pc_q        <= '0;
            alu_q       <= '0;
            br_q        <= '0;
            rdata_q     <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            wb_sel_q    <= '0;
            load_type_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            if (in_load) begin
                pc_q        <= in_pc;
                alu_q       <= in_alu;
                br_q        <= in_br;
                rdata_q     <= in_rdata;
                rd_q        <= in_rd;
                regwrite_q  <= in_regwrite;
                wb_sel_q    <= in_wb_sel;
                load_type_q <= in_load_type;
            end
            // A bundle is live only in the cycle right after its capture edge.
            fresh_q <= in_load & in_valid;
            cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (fresh_q && !mis_cond) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        off     = alu_q[1:0];
        is_byte = (load_type_q == 3'b000) || (load_type_q == 3'b100);
        is_half = (load_type_q == 3'b001) || (load_type_q == 3'b101);
        // Unlisted funct3 encodings behave as lw.
        is_word = !is_byte && !is_half;

        mis_cond = fresh_q && (wb_sel_q == 2'b01) &&
                   ((is_half && off[0]) || (is_word && (off != 2'b00)));

        byte_v = rdata_q[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata_q[31:16] : rdata_q[15:0];

        if (is_byte) begin
            load_v = {{24{byte_v[7] & ~load_type_q[2]}}, byte_v};
        end else if (is_half) begin
            load_v = {{16{half_v[15] & ~load_type_q[2]}}, half_v};
        end else begin
            load_v = rdata_q;
        end

        case (wb_sel_q)
            2'b00:   wdata_v = alu_q;
            2'b01:   wdata_v = load_v;
            2'b10:   wdata_v = pc_q + 32'd4;
            default: wdata_v = br_q;
        endcase

        we = fresh_q && regwrite_q && (rd_q != 5'd0) && !mis_cond;
    end

    always_comb begin
        rf_we       = we;
        rf_rd       = we ? rd_q : 5'd0;
        rf_wdata    = we ? wdata_v : 32'd0;
        misaligned  = mis_cond;
        cycle_cnt   = cycle_q;
        instret_cnt = instret_q;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 64, giving the width of the cycle and instret counters.
REQ-002 SHALL have port clk, input, 1: the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_load, input, 1: MEM stage-register load enable; 1 = capture the bundle this edge.
REQ-005 SHALL have port in_valid, input, 1: incoming bundle holds a real instruction.
REQ-006 SHALL have port in_pc, input, 32: PC of the incoming instruction.
REQ-007 SHALL have port in_alu, input, 32: ALU result; its low 2 bits are the load byte offset.
REQ-008 SHALL have port in_br, input, 32: compare result, already zero-extended.
REQ-009 SHALL have port in_rd, input, 5: destination register index.
REQ-010 SHALL have port in_regwrite, input, 1: instruction writes rd.
REQ-011 SHALL have port in_wb_sel, input, 2: write-back source; 00 alu, 01 load, 10 pc+4, 11 br.
REQ-012 SHALL have port in_load_type, input, 3: funct3; 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-013 SHALL have port in_rdata, input, 32: dcache read word, word-aligned.
REQ-014 SHALL have port rf_we, output, 1: register-file write enable (also the forwarding valid).
REQ-015 SHALL have port rf_rd, output, 5: register-file write index.
REQ-016 SHALL have port rf_wdata, output, 32: register-file write data.
REQ-017 SHALL have port misaligned, output, 1: one-cycle pulse on a retiring misaligned load.
REQ-018 SHALL have ports cycle_cnt and instret_cnt, output, CNT_WIDTH each: free-running counters.

Function
REQ-019 SHALL capture all in_* fields into an internal bundle register on each clk edge with in_load=1 and rst=0; with in_load=0 the bundle register SHALL hold.
REQ-020 SHALL keep a fresh bit: set to in_valid on a capture edge; cleared on any edge with in_load=0.
REQ-021 SHALL retire the bundle in the cycle where fresh=1, so each captured valid bundle retires exactly once, one cycle after capture, even when MEM stalls for N cycles.
REQ-022 SHALL drive rf_we = fresh & regwrite & (rd != 0) & ~misaligned_cond, combinationally from registered state only.
REQ-023 SHALL drive rf_rd and rf_wdata from the registered bundle whenever rf_we=1, and SHALL drive both as 0 when rf_we=0.
REQ-024 SHALL form wdata as: sel 00 -> alu; 01 -> aligned load; 10 -> pc+4 (mod 2^32); 11 -> br.
REQ-025 SHALL align loads as: byte = rdata[8*off+7:8*off]; half = rdata[16*off[1]+15:16*off[1]]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes rdata unchanged (off = alu[1:0]).
REQ-026 SHALL set misaligned_cond = fresh & sel==01 & ((lh|lhu) & off[0] | lw & off!=0); misaligned SHALL equal misaligned_cond.
REQ-027 SHALL treat an unlisted load_type with sel=01 as lw for data and for alignment checks.
REQ-028 SHALL increment instret_cnt by 1 in each retiring cycle (fresh=1) without misaligned_cond, including instructions that write no register and writes to x0.
REQ-029 SHALL increment cycle_cnt every cycle rst=0; both counters SHALL wrap to 0 past 2^CNT_WIDTH-1.
REQ-030 SHALL have all outputs combinational from registered state, giving zero added latency beyond the bundle register: capture at edge k, rf_we high during cycle k..k+1.
REQ-031 SHALL retire a new bundle on the edge that loads it back-to-back with the previous one, so consecutive in_load=1 cycles give consecutive one-cycle retirements.

Reset
REQ-032 SHALL, while rst=1 at an edge, clear fresh, the bundle register, cycle_cnt and instret_cnt to 0; rst SHALL override a simultaneous in_load=1.
REQ-033 SHALL produce rf_we=0, rf_rd=0, rf_wdata=0, misaligned=0 and both counters 0 in the cycle after reset.
REQ-034 SHALL discard a bundle captured before a mid-operation reset, which never retires.

Verification
REQ-035 SHALL cover lb: alu=0x1003, rdata=0x80FF_1234, sel=01, rd=5, in_load 1 cycle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xFFFF_FF80, instret+1.
REQ-036 SHALL cover a stalled MEM: capture an addi with rd=3, alu=7, then in_load=0 for 4 cycles -> rf_we high exactly 1 cycle, instret incremented by 1, cycle_cnt by 5.
REQ-037 SHALL cover a misaligned load: lh with alu=0x2001 -> misaligned=1 for 1 cycle, rf_we=0, instret unchanged.
REQ-038 SHALL cover jal: sel=10, pc=0xFFFF_FFFC, rd=1 -> rf_wdata=0x0000_0000; and rd=0 with regwrite=1 -> rf_we=0, instret+1.
REQ-039 SHALL cover rst=1 together with in_load=1 and in_valid=1 -> next cycle rf_we=0 and counters 0; set CNT_WIDTH=4, run 16 cycles -> cycle_cnt wraps to 0.
